// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative unsigned shift-and-add multiplier
//
// Purpose: multiply stage of the bit-serial MAC datapath. Operands are
//   captured on an accepted start strobe, WIDTH add/shift iterations follow,
//   and the 2*WIDTH-bit product is published together with a one-cycle done.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   start         request strobe, sampled only in IDLE
//   multiplicand  unsigned operand A, captured on the accepted start edge
//   multiplier    unsigned operand B, captured on the accepted start edge
//   product       registered result, holds the last completed result
//   done          registered one-cycle completion pulse
//   busy          high in BUSY and DONE (only with SEQ_MULT_BUSY_PORT_EN)
//
// Optional feature macro: SEQ_MULT_BUSY_PORT_EN adds the busy output.

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
`ifdef SEQ_MULT_BUSY_PORT_EN
  ,
  output logic                 busy
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_iter;

  // Partial-product add for the current iteration; also the final product
  // on the last iteration so it can be published in the same edge.
  assign acc_sum   = acc + (b_reg[0] ? a_reg : '0);
  assign last_iter = (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= {{WIDTH{1'b0}}, multiplicand};
            b_reg <= multiplier;
            acc   <= '0;
            count <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          count <= count + 1'b1;
          if (last_iter) begin
            product <= acc_sum;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_MULT_BUSY_PORT_EN
  // Registered copy of "next state is not IDLE": rises on the edge that
  // accepts start and falls on the edge that leaves DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier

module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] product;
  logic        done;
`ifdef SEQ_MULT_BUSY_PORT_EN
  logic        busy;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  seq_multiplier #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done)
`ifdef SEQ_MULT_BUSY_PORT_EN
    ,
    .busy         (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_busy(input string tag, input logic exp);
`ifdef SEQ_MULT_BUSY_PORT_EN
    check(tag, {31'd0, busy}, {31'd0, exp});
`else
    if (tag.len() < 0) $display("%b", exp);
`endif
  endtask

  // One full operation: start accepted at edge T0, checks sampled on the
  // falling edge after every edge through T17. poke_at > 0 pulses start with
  // A=3,B=3 at that iteration to confirm it is ignored.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input logic [31:0] prev, input int poke_at);
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(negedge clk);
    start = 1'b0; multiplicand = 16'($urandom); multiplier = 16'($urandom);
    check_busy({tag, "_busy_t0"}, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check({tag, "_done_low"}, {31'd0, done}, 32'd0);
      check({tag, "_prod_hold"}, product, prev);
      if (i == poke_at) begin
        start = 1'b1; multiplicand = 16'd3; multiplier = 16'd3;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    check({tag, "_prod"}, product, exp);
    check_busy({tag, "_busy_t16"}, 1'b1);
    @(negedge clk);
    check({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    check({tag, "_prod_kept"}, product, exp);
    check_busy({tag, "_busy_t17"}, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;

    // Reset held 100 ns with random inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_prod", product, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check_busy("rst_busy", 1'b0);
      start = 1'($urandom); multiplicand = 16'($urandom); multiplier = 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_prod", product, 32'd0);

    do_mul("ff_ff",     16'h00FF, 16'h00FF, 32'h0000FE01, 32'h00000000, 0);
    do_mul("ffff_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h0000FE01, 0);
    do_mul("ffff_1",    16'hFFFF, 16'h0001, 32'h0000FFFF, 32'hFFFE0001, 0);
    do_mul("zero_a",    16'h0000, 16'h1234, 32'h00000000, 32'h0000FFFF, 0);
    do_mul("poke",      16'h0123, 16'h0045, 32'h00004E6F, 32'h00000000, 5);

    // The ignored mid-operation start must not spawn a second operation.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("poke_no_second_done", {31'd0, done}, 32'd0);
      check("poke_prod_hold", product, 32'h00004E6F);
    end

    // Reset at iteration 8 aborts the operation.
    @(negedge clk);
    start = 1'b1; multiplicand = 16'h1234; multiplier = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_prod_async", product, 32'd0);
    check("abort_done_async", {31'd0, done}, 32'd0);
    check_busy("abort_busy_async", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
      check("abort_prod_zero", product, 32'd0);
    end

    do_mul("seven_nine", 16'h0007, 16'h0009, 32'h0000003F, 32'h00000000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
